// File: rtl/imm_pkg.sv
// Shared types for the immediate generator: immediate kinds, RV opcodes, buffer states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_Z    = 3'd6
    } imm_type_e;

    // Encoding doubles as the occupancy count of the output buffer
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / immediate-out bus with valid/ready on both sides.
// Latency: n/a (wiring only).
// Backpressure: in_ready from the buffer, out_ready from the consumer.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           inst;
    logic [TAG_W-1:0]      in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       out_imm;
    imm_pkg::imm_type_e    out_type;
    logic                  out_illegal;
    logic [TAG_W-1:0]      out_tag;

    modport master (
        output in_valid, inst, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_type, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, inst, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_type, out_illegal, out_tag
    );
endinterface

// File: rtl/imm_gen_core.sv
// Combinational RV immediate decoder: inst -> extended imm, kind, illegal flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when the result is captured.
module imm_gen_core
    import imm_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit EN_ZIMM = 1'b1
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output imm_type_e       imm_type,
    output logic            illegal
);

    logic [6:0] opcode;
    assign opcode = inst[6:0];

    // Signed width casts give sign extension to XLEN for both 32 and 64
    always_comb begin
        imm      = '0;
        imm_type = IMM_NONE;
        illegal  = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
                imm      = XLEN'($signed(inst[31:20]));
                imm_type = IMM_I;
            end
            OPC_STORE: begin
                imm      = XLEN'($signed({inst[31:25], inst[11:7]}));
                imm_type = IMM_S;
            end
            OPC_BRANCH: begin
                imm      = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
                imm_type = IMM_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm      = XLEN'($signed({inst[31:12], 12'b0}));
                imm_type = IMM_U;
            end
            OPC_JAL: begin
                imm      = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
                imm_type = IMM_J;
            end
            OPC_OP: begin
                imm_type = IMM_NONE;
            end
            OPC_SYSTEM: begin
                if (!EN_ZIMM) begin
                    illegal = 1'b1;
                end else if (inst[14]) begin
                    imm      = XLEN'(inst[19:15]);
                    imm_type = IMM_Z;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry FIFO output buffer and sideband tag.
// Latency: 1 cycle push-to-out_valid, no same-cycle bypass.
// Backpressure: in_ready = buffer not full (state only); entries held while out_ready is low.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 8,
    parameter bit EN_ZIMM = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    imm_gen_pipe_if.slave  bus
);

    buf_state_e        state_q, state_d;
    logic              wr_ptr, rd_ptr;
    logic              push, pop;

    logic [XLEN-1:0]   imm_q     [2];
    imm_type_e         type_q    [2];
    logic              illegal_q [2];
    logic [TAG_W-1:0]  tag_q     [2];

    logic [XLEN-1:0]   dec_imm;
    imm_type_e         dec_type;
    logic              dec_illegal;

    imm_gen_core #(
        .XLEN    (XLEN),
        .EN_ZIMM (EN_ZIMM)
    ) u_core (
        .inst     (bus.inst),
        .imm      (dec_imm),
        .imm_type (dec_type),
        .illegal  (dec_illegal)
    );

    assign bus.in_ready  = (state_q != BUF_FULL);
    assign bus.out_valid = (state_q != BUF_EMPTY);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= BUF_EMPTY;
        else        state_q <= state_d;
    end

    // Flush wins over any same-cycle push; a same-cycle pop has already transferred
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = BUF_EMPTY;
        end else begin
            case (state_q)
                BUF_EMPTY: if (push) state_d = BUF_ONE;
                BUF_ONE: begin
                    if (push && !pop)      state_d = BUF_FULL;
                    else if (pop && !push) state_d = BUF_EMPTY;
                end
                BUF_FULL:  if (pop) state_d = BUF_ONE;
                default:   state_d = BUF_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                imm_q[i]     <= '0;
                type_q[i]    <= IMM_NONE;
                illegal_q[i] <= 1'b0;
                tag_q[i]     <= '0;
            end
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                imm_q[wr_ptr]     <= dec_imm;
                type_q[wr_ptr]    <= dec_type;
                illegal_q[wr_ptr] <= dec_illegal;
                tag_q[wr_ptr]     <= bus.in_tag;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
        end
    end

    assign bus.out_imm     = imm_q[rd_ptr];
    assign bus.out_type    = type_q[rd_ptr];
    assign bus.out_illegal = illegal_q[rd_ptr];
    assign bus.out_tag     = tag_q[rd_ptr];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode table on XLEN=32, XLEN=64 extension,
// backpressure, flush and asynchronous reset sequences.
module tb_imm_gen_pipe;
    import imm_pkg::*;

    logic clk;
    logic rst_n;
    logic flush;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(8)) b32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(8)) b64 ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .EN_ZIMM(1'b1)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (b32.slave)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .EN_ZIMM(1'b1)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (b64.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] imm;
        logic [2:0]  typ;
        logic        ill;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_out_valid"}, 64'(b32.out_valid), 64'd0);
        chk({nm, "_in_ready"},  64'(b32.in_ready), 64'd1);
        chk({nm, "_imm"},       64'(b32.out_imm), 64'd0);
        chk({nm, "_type"},      64'(b32.out_type), 64'(IMM_NONE));
        chk({nm, "_illegal"},   64'(b32.out_illegal), 64'd0);
        chk({nm, "_tag"},       64'(b32.out_tag), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{32'hFFF00093, 64'hFFFFFFFF, 3'(IMM_I), 1'b0};   // addi -1
        vecs[1]  = '{32'h123450B7, 64'h12345000, 3'(IMM_U), 1'b0};   // lui
        vecs[2]  = '{32'hFFDFF06F, 64'hFFFFFFFC, 3'(IMM_J), 1'b0};   // jal -4
        vecs[3]  = '{32'h3002D073, 64'h00000005, 3'(IMM_Z), 1'b0};   // csrrwi zimm=5
        vecs[4]  = '{32'hFE512C23, 64'hFFFFFFF8, 3'(IMM_S), 1'b0};   // sw -8
        vecs[5]  = '{32'h00000863, 64'h00000010, 3'(IMM_B), 1'b0};   // beq +16
        vecs[6]  = '{32'hFE000EE3, 64'hFFFFFFFC, 3'(IMM_B), 1'b0};   // beq -4
        vecs[7]  = '{32'h003100B3, 64'h00000000, 3'(IMM_NONE), 1'b0}; // add
        vecs[8]  = '{32'h00000073, 64'h00000000, 3'(IMM_NONE), 1'b0}; // ecall
        vecs[9]  = '{32'h0000007F, 64'h00000000, 3'(IMM_NONE), 1'b1}; // bad opcode
        vecs[10] = '{32'h00001117, 64'h00001000, 3'(IMM_U), 1'b0};   // auipc
        vecs[11] = '{32'h7FF02083, 64'h000007FF, 3'(IMM_I), 1'b0};   // lw +2047
        vecs[12] = '{32'h80008067, 64'hFFFFF800, 3'(IMM_I), 1'b0};   // jalr -2048

        clk = 1'b0;
        rst_n = 1'b0;
        flush = 1'b0;
        b32.in_valid = 1'b0; b32.inst = '0; b32.in_tag = '0; b32.out_ready = 1'b0;
        b64.in_valid = 1'b0; b64.inst = '0; b64.in_tag = '0; b64.out_ready = 1'b0;

        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", 64'(b32.in_ready), 64'd1);

        // Streaming decode table, one instruction per cycle with out_ready held high
        b32.out_ready = 1'b1;
        for (int i = 0; i <= NV; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("vec%0d_valid", i-1), 64'(b32.out_valid), 64'd1);
                chk($sformatf("vec%0d_imm", i-1), 64'(b32.out_imm), vecs[i-1].imm);
                chk($sformatf("vec%0d_type", i-1), 64'(b32.out_type), 64'(vecs[i-1].typ));
                chk($sformatf("vec%0d_illegal", i-1), 64'(b32.out_illegal), 64'(vecs[i-1].ill));
                chk($sformatf("vec%0d_tag", i-1), 64'(b32.out_tag), 64'(i-1));
            end
            if (i < NV) begin
                b32.in_valid = 1'b1;
                b32.inst     = vecs[i].inst;
                b32.in_tag   = 8'(i);
            end else begin
                b32.in_valid = 1'b0;
            end
            if (i == 0) begin
                #1;
                chk("no_bypass", 64'(b32.out_valid), 64'd0);
            end
        end
        @(negedge clk);
        chk("stream_drained", 64'(b32.out_valid), 64'd0);

        // XLEN=64 extension
        b64.out_ready = 1'b1;
        b64.in_valid = 1'b1; b64.inst = 32'hFFF00093; b64.in_tag = 8'd1;
        @(negedge clk);
        chk("x64_i_valid", 64'(b64.out_valid), 64'd1);
        chk("x64_i_imm", b64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("x64_i_type", 64'(b64.out_type), 64'(IMM_I));
        b64.inst = 32'h0000007F; b64.in_tag = 8'd2;
        @(negedge clk);
        chk("x64_ill_imm", b64.out_imm, 64'd0);
        chk("x64_ill_type", 64'(b64.out_type), 64'(IMM_NONE));
        chk("x64_ill_flag", 64'(b64.out_illegal), 64'd1);
        chk("x64_ill_tag", 64'(b64.out_tag), 64'd2);
        b64.in_valid = 1'b0;
        @(negedge clk);
        chk("x64_drained", 64'(b64.out_valid), 64'd0);

        // Backpressure: three offers with the consumer stalled
        b32.out_ready = 1'b0;
        b32.in_valid = 1'b1; b32.inst = 32'h123450B7; b32.in_tag = 8'd1;
        @(negedge clk);
        chk("bp_ready_after1", 64'(b32.in_ready), 64'd1);
        b32.in_tag = 8'd2;
        @(negedge clk);
        chk("bp_ready_after2", 64'(b32.in_ready), 64'd0);
        chk("bp_head_tag1", 64'(b32.out_tag), 64'd1);
        b32.in_tag = 8'd3;
        @(negedge clk);
        chk("bp_hold_ready", 64'(b32.in_ready), 64'd0);
        chk("bp_hold_tag", 64'(b32.out_tag), 64'd1);
        chk("bp_hold_imm", 64'(b32.out_imm), 64'h12345000);
        b32.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_tag2", 64'(b32.out_tag), 64'd2);
        chk("bp_rel_ready", 64'(b32.in_ready), 64'd1);
        @(negedge clk);
        b32.in_valid = 1'b0;
        chk("bp_rel_tag3", 64'(b32.out_tag), 64'd3);
        chk("bp_rel_valid3", 64'(b32.out_valid), 64'd1);
        @(negedge clk);
        chk("bp_drained", 64'(b32.out_valid), 64'd0);

        // Flush a full buffer with a competing push
        b32.out_ready = 1'b0;
        b32.in_valid = 1'b1; b32.inst = 32'hFFF00093; b32.in_tag = 8'd4;
        @(negedge clk);
        b32.in_tag = 8'd5;
        @(negedge clk);
        chk("fl_full", 64'(b32.in_ready), 64'd0);
        flush = 1'b1; b32.in_tag = 8'd9;
        @(negedge clk);
        flush = 1'b0; b32.in_valid = 1'b0;
        chk("fl_out_valid", 64'(b32.out_valid), 64'd0);
        chk("fl_in_ready", 64'(b32.in_ready), 64'd1);
        @(negedge clk);
        chk("fl_no_ghost", 64'(b32.out_valid), 64'd0);

        // Flush while full, then a fresh push must appear normally
        b32.in_valid = 1'b1; b32.inst = 32'h00001117; b32.in_tag = 8'd10;
        @(negedge clk);
        b32.in_valid = 1'b0;
        chk("fl_after_tag", 64'(b32.out_tag), 64'd10);
        chk("fl_after_imm", 64'(b32.out_imm), 64'h00001000);
        b32.out_ready = 1'b1;
        @(negedge clk);
        b32.out_ready = 1'b0;

        // Asynchronous reset with two entries held
        b32.in_valid = 1'b1; b32.inst = 32'hFFF00093; b32.in_tag = 8'd6;
        @(negedge clk);
        b32.in_tag = 8'd7;
        @(negedge clk);
        b32.in_valid = 1'b0;
        chk("rst_pre_full", 64'(b32.in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_stays_empty", 64'(b32.out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
